// File: rtl/id_ex_alu_issue_if.sv
// ID -> EX ALU issue bundle: ID-side request signals plus the registered EX-side outputs.
// With ALU_ISSUE_PERF_EN defined, the bundle also carries the issue/bubble counters.
interface id_ex_alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic [31:0]      i_instr;
    logic [WIDTH-1:0] i_rs_data;
    logic [WIDTH-1:0] i_rt_data;
    logic             i_stall;
    logic             i_flush;

    logic             o_valid;
    logic [3:0]       o_alu_ctrl;
    logic [WIDTH-1:0] o_src1;
    logic [WIDTH-1:0] o_src2;
    logic             o_reg_write;
    logic [4:0]       o_dest_reg;
    logic             o_mem_read;
    logic             o_mem_write;
    logic             o_illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]      o_issue_cnt;
    logic [31:0]      o_bubble_cnt;

    modport master (
        output i_valid, i_instr, i_rs_data, i_rt_data, i_stall, i_flush,
        input  o_valid, o_alu_ctrl, o_src1, o_src2, o_reg_write, o_dest_reg,
               o_mem_read, o_mem_write, o_illegal, o_issue_cnt, o_bubble_cnt
    );
    modport slave (
        input  i_valid, i_instr, i_rs_data, i_rt_data, i_stall, i_flush,
        output o_valid, o_alu_ctrl, o_src1, o_src2, o_reg_write, o_dest_reg,
               o_mem_read, o_mem_write, o_illegal, o_issue_cnt, o_bubble_cnt
    );
`else
    modport master (
        output i_valid, i_instr, i_rs_data, i_rt_data, i_stall, i_flush,
        input  o_valid, o_alu_ctrl, o_src1, o_src2, o_reg_write, o_dest_reg,
               o_mem_read, o_mem_write, o_illegal
    );
    modport slave (
        input  i_valid, i_instr, i_rs_data, i_rt_data, i_stall, i_flush,
        output o_valid, o_alu_ctrl, o_src1, o_src2, o_reg_write, o_dest_reg,
               o_mem_read, o_mem_write, o_illegal
    );
`endif
endinterface

// File: rtl/id_ex_alu_issue.sv
// MIPS ID-stage ALU decode feeding the ID/EX pipeline register (stall/flush aware).
// Optional perf counters o_issue_cnt/o_bubble_cnt are enabled with ALU_ISSUE_PERF_EN.
module id_ex_alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    id_ex_alu_issue_if.slave      bus
);
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
        ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef struct packed {
        logic             valid;
        alu_op_e          alu_ctrl;
        logic [WIDTH-1:0] src1;
        logic [WIDTH-1:0] src2;
        logic             reg_write;
        logic [4:0]       dest;
        logic             mem_read;
        logic             mem_write;
        logic             illegal;
    } ex_t;

    logic [5:0]       op, funct;
    logic [4:0]       rt, rd, shamt;
    logic [15:0]      imm;
    logic [WIDTH-1:0] imm_se, imm_ze;
    logic             legal;
    ex_t              dec;
    ex_t              ex_d, ex_q;

    assign op     = bus.i_instr[31:26];
    assign rt     = bus.i_instr[20:16];
    assign rd     = bus.i_instr[15:11];
    assign shamt  = bus.i_instr[10:6];
    assign funct  = bus.i_instr[5:0];
    assign imm    = bus.i_instr[15:0];
    assign imm_se = WIDTH'({{16{imm[15]}}, imm});
    assign imm_ze = WIDTH'(imm);

    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    always_comb begin
        dec           = '0;
        legal         = 1'b1;
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        dec.src1      = bus.i_rs_data;
        dec.src2      = imm_se;
        dec.dest      = rt;
        case (op)
            6'h00: begin
                dec.dest = rd;
                dec.src2 = bus.i_rt_data;
                case (funct)
                    6'h20, 6'h21: dec.alu_ctrl = ALU_ADD;
                    6'h22, 6'h23: dec.alu_ctrl = ALU_SUB;
                    6'h24:        dec.alu_ctrl = ALU_AND;
                    6'h25:        dec.alu_ctrl = ALU_OR;
                    6'h26:        dec.alu_ctrl = ALU_XOR;
                    6'h2A:        dec.alu_ctrl = ALU_SLT;
                    6'h2B:        dec.alu_ctrl = ALU_SLTU;
                    6'h00, 6'h02, 6'h03: begin
                        dec.src1 = bus.i_rt_data;
                        dec.src2 = WIDTH'(shamt);
                        dec.alu_ctrl = (funct == 6'h00) ? ALU_SLL :
                                       (funct == 6'h02) ? ALU_SRL : ALU_SRA;
                    end
                    6'h04, 6'h06, 6'h07: begin
                        dec.src1 = bus.i_rt_data;
                        dec.src2 = bus.i_rs_data;
                        dec.alu_ctrl = (funct == 6'h04) ? ALU_SLL :
                                       (funct == 6'h06) ? ALU_SRL : ALU_SRA;
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: dec.alu_ctrl = ALU_ADD;
            6'h0A:        dec.alu_ctrl = ALU_SLT;
            6'h0B:        dec.alu_ctrl = ALU_SLTU;
            6'h0C: begin dec.alu_ctrl = ALU_AND; dec.src2 = imm_ze; end
            6'h0D: begin dec.alu_ctrl = ALU_OR;  dec.src2 = imm_ze; end
            6'h0E: begin dec.alu_ctrl = ALU_XOR; dec.src2 = imm_ze; end
            6'h0F: begin
                dec.alu_ctrl = ALU_OR;
                dec.src1     = '0;
                dec.src2     = WIDTH'({imm, 16'h0000});
            end
            6'h23: dec.mem_read = 1'b1;
            6'h2B: begin dec.mem_write = 1'b1; dec.reg_write = 1'b0; end
            6'h04, 6'h05: begin
                dec.alu_ctrl  = ALU_SUB;
                dec.src2      = bus.i_rt_data;
                dec.reg_write = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
        // $zero is never a real writeback target.
        if (dec.dest == 5'd0) dec.reg_write = 1'b0;
    end

    // A bubble is the all-zero record, which also encodes alu_ctrl = ADD.
    always_comb begin
        ex_d = ex_q;
        if (bus.i_flush)       ex_d = '0;
        else if (bus.i_stall)  ex_d = ex_q;
        else if (!bus.i_valid) ex_d = '0;
        else                   ex_d = dec;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign bus.o_valid     = ex_q.valid;
    assign bus.o_alu_ctrl  = ex_q.alu_ctrl;
    assign bus.o_src1      = ex_q.src1;
    assign bus.o_src2      = ex_q.src2;
    assign bus.o_reg_write = ex_q.reg_write;
    assign bus.o_dest_reg  = ex_q.dest;
    assign bus.o_mem_read  = ex_q.mem_read;
    assign bus.o_mem_write = ex_q.mem_write;
    assign bus.o_illegal   = ex_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issue_cnt_d, issue_cnt_q, bubble_cnt_d, bubble_cnt_q;
    logic        capture, bubble;

    // Flush always inserts a bubble; an idle slot only does when not stalled.
    assign capture = !bus.i_flush && !bus.i_stall && bus.i_valid;
    assign bubble  = bus.i_flush || (!bus.i_stall && !bus.i_valid);

    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (capture && (issue_cnt_q != 32'hFFFF_FFFF))  issue_cnt_d  = issue_cnt_q + 32'd1;
        if (bubble  && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.o_issue_cnt  = issue_cnt_q;
    assign bus.o_bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed cases from the feature list, then random traffic.
// Expected records come from an instruction-level reference model; a monitor compares every cycle.
module tb_id_ex_alu_issue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_ex_alu_issue_if #(.WIDTH(32)) bus ();

    id_ex_alu_issue #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic        rw;
        logic [4:0]  dest;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   total = 0;
    int   bad   = 0;
    int   m_issue = 0;
    int   m_bubble = 0;

    // Reference: what the EX stage should see for one instruction, straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] se;
        logic [31:0] ze;
        bit          ok;
        op = ins[31:26];
        fn = ins[5:0];
        ze = {16'h0000, ins[15:0]};
        se = {{16{ins[15]}}, ins[15:0]};
        ok = 1'b1;
        e = '0;
        e.valid = 1'b1;
        e.rw = 1'b1;
        if (op == 6'h00) begin
            e.dest = ins[15:11];
            e.src1 = a;
            e.src2 = b;
            case (fn)
                6'h20, 6'h21: e.ctrl = 4'd0;
                6'h22, 6'h23: e.ctrl = 4'd1;
                6'h24: e.ctrl = 4'd2;
                6'h25: e.ctrl = 4'd3;
                6'h26: e.ctrl = 4'd4;
                6'h2A: e.ctrl = 4'd8;
                6'h2B: e.ctrl = 4'd9;
                6'h00: begin e.ctrl = 4'd5; e.src1 = b; e.src2 = 32'(ins[10:6]); end
                6'h02: begin e.ctrl = 4'd6; e.src1 = b; e.src2 = 32'(ins[10:6]); end
                6'h03: begin e.ctrl = 4'd7; e.src1 = b; e.src2 = 32'(ins[10:6]); end
                6'h04: begin e.ctrl = 4'd5; e.src1 = b; e.src2 = a; end
                6'h06: begin e.ctrl = 4'd6; e.src1 = b; e.src2 = a; end
                6'h07: begin e.ctrl = 4'd7; e.src1 = b; e.src2 = a; end
                default: ok = 1'b0;
            endcase
        end else begin
            e.dest = ins[20:16];
            e.src1 = a;
            case (op)
                6'h08, 6'h09: begin e.ctrl = 4'd0; e.src2 = se; end
                6'h0A: begin e.ctrl = 4'd8; e.src2 = se; end
                6'h0B: begin e.ctrl = 4'd9; e.src2 = se; end
                6'h0C: begin e.ctrl = 4'd2; e.src2 = ze; end
                6'h0D: begin e.ctrl = 4'd3; e.src2 = ze; end
                6'h0E: begin e.ctrl = 4'd4; e.src2 = ze; end
                6'h0F: begin e.ctrl = 4'd3; e.src1 = 0; e.src2 = ze << 16; end
                6'h23: begin e.ctrl = 4'd0; e.src2 = se; e.mr = 1'b1; end
                6'h2B: begin e.ctrl = 4'd0; e.src2 = se; e.mw = 1'b1; e.rw = 1'b0; end
                6'h04, 6'h05: begin e.ctrl = 4'd1; e.src2 = b; e.rw = 1'b0; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            e = '0;
            e.valid = 1'b1;
            e.ill = 1'b1;
        end
        if (e.dest == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got v=%b ctl=%h s1=%h s2=%h rw=%b d=%0d mr=%b mw=%b il=%b, want v=%b ctl=%h s1=%h s2=%h rw=%b d=%0d mr=%b mw=%b il=%b",
                     name, act.valid, act.ctrl, act.src1, act.src2, act.rw, act.dest, act.mr, act.mw, act.ill,
                     exp.valid, exp.ctrl, exp.src1, exp.src2, exp.rw, exp.dest, exp.mr, exp.mw, exp.ill);
        end
    endtask

    // One clock of stimulus; the expected EX-stage record after the next edge goes into the queue.
    task automatic step(input bit r, input bit v, input bit st, input bit fl,
                        input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.i_valid   = v;
        bus.i_stall   = st;
        bus.i_flush   = fl;
        bus.i_instr   = ins;
        bus.i_rs_data = a;
        bus.i_rt_data = b;
        if (r) begin
            e = '0; m_issue = 0; m_bubble = 0;
        end else if (fl) begin
            e = '0; m_bubble++;
        end else if (st) begin
            e = last_exp;
        end else if (!v) begin
            e = '0; m_bubble++;
        end else begin
            e = model(ins, a, b); m_issue++;
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
    endtask

    // Monitor: the registered outputs are valid every cycle, so one record is consumed per edge.
    initial begin : monitor
        exp_t act;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.o_valid, bus.o_alu_ctrl, bus.o_src1, bus.o_src2, bus.o_reg_write,
                       bus.o_dest_reg, bus.o_mem_read, bus.o_mem_write, bus.o_illegal};
                check("ex_out", act, e);
            end
        end
    end

    logic [5:0] legal_ops[13] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [5:0] legal_fn[16]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A,
                                  6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};

    initial begin : stimulus
        logic [31:0] ins;
        int          wait_cycles;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
        bus.i_instr = '0; bus.i_rs_data = '0; bus.i_rt_data = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h2008FFFF, 32'h1, 32'h2);
        idle();
        idle();
        // ADDI $8, $0, -1 with rs_data 5
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h2008FFFF, 32'd5, 32'd0);
        // SRA $10, $9, 4
        step(1'b0, 1'b1, 1'b0, 1'b0, (32'd9 << 16) | (32'd10 << 11) | (32'd4 << 6) | 32'h03,
             32'h1234, 32'h8000_0000);
        // ORI $2, $1, 0x8000 (zero-extended)
        step(1'b0, 1'b1, 1'b0, 1'b0, (32'h0D << 26) | (32'd1 << 21) | (32'd2 << 16) | 32'h8000,
             32'h0F0F_0000, 32'h0);
        // LW then three stalled cycles presenting SW
        step(1'b0, 1'b1, 1'b0, 1'b0, (32'h23 << 26) | (32'd3 << 21) | (32'd4 << 16) | 32'hFFF0,
             32'h1000, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, (32'h2B << 26) | (32'd5 << 21) | (32'd6 << 16) | 32'h0010,
                 32'h2000, 32'h77);
        // stall and flush together: flush wins
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h2008FFFF, 32'd5, 32'd0);
        // illegal op 0x3F
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFC00_1234, 32'hAAAA, 32'hBBBB);
        // ADD with rd = 0
        step(1'b0, 1'b1, 1'b0, 1'b0, (32'd1 << 21) | (32'd2 << 16) | 32'h20, 32'd3, 32'd4);
        // BEQ
        step(1'b0, 1'b1, 1'b0, 1'b0, (32'h04 << 26) | (32'd1 << 21) | (32'd2 << 16) | 32'h0003,
             32'd9, 32'd9);
        // reset asserted during stall and flush
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h2008FFFF, 32'd5, 32'd0);
        idle();

        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                ins[31:26] = legal_ops[$urandom_range(0, 12)];
                if (ins[31:26] == 6'h00) ins[5:0] = legal_fn[$urandom_range(0, 15)];
            end
            if ($urandom_range(0, 7) == 0) ins[20:11] = '0;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                 ins, $urandom, $urandom);
        end

`ifdef ALU_ISSUE_PERF_EN
        // 10 valid, 3 flush and 2 stall cycles from a clean reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b1, (i == 4) || (i == 9), (i == 2) || (i == 7) || (i == 12),
                 32'h2008_0001 + 32'(i), $urandom, $urandom);
        @(posedge clk);
        #2;
        total++;
        if (bus.o_issue_cnt !== 32'(m_issue) || bus.o_bubble_cnt !== 32'(m_bubble)) begin
            bad++;
            $display("FAIL perf_cnt: got issue=%0d bubble=%0d, want issue=%0d bubble=%0d",
                     bus.o_issue_cnt, bus.o_bubble_cnt, m_issue, m_bubble);
        end
`endif

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d records left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
